// File: rtl/cnn_pkg.sv
// Shared widths, saturation limits and result-tag layout for the CNN conv datapath.
package cnn_pkg;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 36;
   localparam int TAG_W  = 6;
   localparam int PROD_W = 2 * DATA_W;

   localparam logic signed [ACC_W-1:0] SAT_MAX = 36'sd32767;
   localparam logic signed [ACC_W-1:0] SAT_MIN = -36'sd32768;

   typedef struct packed {
      logic [1:0] layer;
      logic [1:0] quad;
      logic [1:0] subblock;
   } conv_tag_t;

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous FIFO for finished window results; a push into a full queue succeeds
// when a pop happens in the same cycle.
module conv_out_fifo #(
   parameter int WIDTH = 22,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != FULL_CNT) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);

endmodule

// File: rtl/conv_mac_accum.sv
// Nine-term 3x3 window MAC: operand, product and accumulate stages, then scale/saturate
// into the output FIFO. Define CONV_RELU_EN to clamp negative results to zero.
module conv_mac_accum
   import cnn_pkg::*;
#(
   parameter int FRAC_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_pixel,
   input  logic signed [DATA_W-1:0] in_weight,
   input  logic                     in_last,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [TAG_W-1:0]         out_addr,
   output logic                     busy,
   output logic                     err_frame,
   output logic                     err_drop,
   input  logic                     err_clear
);
   localparam int FIFO_W = DATA_W + TAG_W;

   function automatic logic signed [DATA_W-1:0] scale_sat(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0]  shifted;
      logic signed [DATA_W-1:0] res;
      shifted = acc >>> FRAC_BITS;
      if (shifted > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
      else if (shifted < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
      else                        res = shifted[DATA_W-1:0];
`ifdef CONV_RELU_EN
      if (res[DATA_W-1]) res = '0;
`endif
      return res;
   endfunction

   logic [3:0]               tcnt_q, tcnt_d;
   logic                     tcnt_end, frame_good;
   logic                     vld_p0_q, vld_p0_d, end_p0_q, end_p0_d, first_p0_q, first_p0_d;
   logic signed [DATA_W-1:0] pix_p0_q, pix_p0_d, wgt_p0_q, wgt_p0_d;
   conv_tag_t                tag_p0_q, tag_p0_d;
   logic                     vld_p1_q, vld_p1_d, end_p1_q, end_p1_d, first_p1_q, first_p1_d;
   logic signed [PROD_W-1:0] prod_p1_q, prod_p1_d;
   conv_tag_t                tag_p1_q, tag_p1_d;
   logic                     vld_p2_q, vld_p2_d, done_p2_q, done_p2_d;
   logic signed [ACC_W-1:0]  acc_p2_q, acc_p2_d;
   conv_tag_t                tag_p2_q, tag_p2_d;
   logic                     err_frame_q, err_frame_d, err_drop_q, err_drop_d, busy_q, busy_d;
   logic                     push, pop, fifo_full, fifo_empty;
   logic [FIFO_W-1:0]        push_data, pop_data;

   always_comb begin
      // A beat is well framed when in_last coincides exactly with the ninth term.
      tcnt_end   = (tcnt_q == 4'd8);
      frame_good = (in_last == tcnt_end);
      tcnt_d     = tcnt_q;
      if (in_valid) tcnt_d = (in_last || tcnt_end) ? 4'd0 : tcnt_q + 4'd1;

      // p0: registered operands and framing
      vld_p0_d   = in_valid;
      pix_p0_d   = in_pixel;
      wgt_p0_d   = in_weight;
      end_p0_d   = in_valid && in_last && frame_good;
      first_p0_d = (tcnt_q == 4'd0);
      tag_p0_d   = conv_tag_t'(in_tag);

      // p1: product
      vld_p1_d   = vld_p0_q;
      prod_p1_d  = PROD_W'(pix_p0_q) * PROD_W'(wgt_p0_q);
      end_p1_d   = vld_p0_q && end_p0_q;
      first_p1_d = first_p0_q;
      tag_p1_d   = tag_p0_q;

      // p2: accumulate; a window's first term reloads, which also discards a misframed partial
      vld_p2_d  = vld_p1_q;
      done_p2_d = vld_p1_q && end_p1_q;
      tag_p2_d  = tag_p1_q;
      acc_p2_d  = acc_p2_q;
      if (vld_p1_q) acc_p2_d = first_p1_q ? ACC_W'(prod_p1_q) : acc_p2_q + ACC_W'(prod_p1_q);

      push        = done_p2_q;
      push_data   = {tag_p2_q, scale_sat(acc_p2_q)};
      pop         = out_valid && out_ready;
      err_frame_d = (in_valid && !frame_good) || (err_frame_q && !err_clear);
      err_drop_d  = (push && fifo_full && !pop) || (err_drop_q && !err_clear);
      busy_d      = (tcnt_q != 4'd0) || vld_p0_q || vld_p1_q || vld_p2_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tcnt_q      <= '0;
         vld_p0_q    <= 1'b0;
         pix_p0_q    <= '0;
         wgt_p0_q    <= '0;
         end_p0_q    <= 1'b0;
         first_p0_q  <= 1'b0;
         tag_p0_q    <= '0;
         vld_p1_q    <= 1'b0;
         prod_p1_q   <= '0;
         end_p1_q    <= 1'b0;
         first_p1_q  <= 1'b0;
         tag_p1_q    <= '0;
         vld_p2_q    <= 1'b0;
         done_p2_q   <= 1'b0;
         acc_p2_q    <= '0;
         tag_p2_q    <= '0;
         err_frame_q <= 1'b0;
         err_drop_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         tcnt_q      <= tcnt_d;
         vld_p0_q    <= vld_p0_d;
         pix_p0_q    <= pix_p0_d;
         wgt_p0_q    <= wgt_p0_d;
         end_p0_q    <= end_p0_d;
         first_p0_q  <= first_p0_d;
         tag_p0_q    <= tag_p0_d;
         vld_p1_q    <= vld_p1_d;
         prod_p1_q   <= prod_p1_d;
         end_p1_q    <= end_p1_d;
         first_p1_q  <= first_p1_d;
         tag_p1_q    <= tag_p1_d;
         vld_p2_q    <= vld_p2_d;
         done_p2_q   <= done_p2_d;
         acc_p2_q    <= acc_p2_d;
         tag_p2_q    <= tag_p2_d;
         err_frame_q <= err_frame_d;
         err_drop_q  <= err_drop_d;
         busy_q      <= busy_d;
      end
   end

   conv_out_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = pop_data[DATA_W-1:0];
   assign out_addr  = pop_data[DATA_W +: TAG_W];
   assign busy      = busy_q;
   assign err_frame = err_frame_q;
   assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_conv_mac_accum.sv
// Directed bench for conv_mac_accum: window table plus multi-cycle corner sequences.
module tb_conv_mac_accum;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_pixel = '0;
   logic [15:0] in_weight = '0;
   logic        in_last = 1'b0;
   logic [5:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic [5:0]  out_addr;
   logic        busy;
   logic        err_frame;
   logic        err_drop;
   logic        err_clear = 1'b0;

`ifdef CONV_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   int n_vec = 0;
   int n_bad = 0;
   logic [21:0] got[$];

   typedef struct {
      int          pix;
      int          wgt;
      int          tag;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs[7];

   always #5 clock = ~clock;

   conv_mac_accum #(.FRAC_BITS(8), .FIFO_DEPTH(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_pixel  (in_pixel),
      .in_weight (in_weight),
      .in_last   (in_last),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .busy      (busy),
      .err_frame (err_frame),
      .err_drop  (err_drop),
      .err_clear (err_clear)
   );

   // Every entry the dom port accepts, in order.
   always @(negedge clock) if (reset && out_valid && out_ready) got.push_back({out_addr, out_data});

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ent(input int tag, input int data);
      return {10'd0, tag[5:0], data[15:0]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_beat(input int p, input int w, input bit last, input int t);
      in_valid  = 1'b1;
      in_pixel  = 16'(p);
      in_weight = 16'(w);
      in_last   = last;
      in_tag    = 6'(t);
      tick();
   endtask

   task automatic send_window(input int p, input int w, input int t);
      for (int i = 0; i < 9; i++) drive_beat(p, w, i == 8, t);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
   endtask

   initial begin
      logic [15:0] e;
      vecs[0] = '{256, 256, 'h2A, 16'd2304};
      vecs[1] = '{32767, 32767, 'h01, 16'h7FFF};
      vecs[2] = '{-32768, 32767, 'h02, 16'h8000};
      vecs[3] = '{100, -50, 'h03, 16'hFF50};
      vecs[4] = '{1, 1, 'h04, 16'd0};
      vecs[5] = '{1000, 300, 'h05, 16'd10546};
      vecs[6] = '{-255, 1, 'h3F, 16'hFFF7};

      #2 reset = 1'b0;
      #2;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_addr", 32'(out_addr), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err_frame", 32'(err_frame), 0);
      check("rst_err_drop", 32'(err_drop), 0);
      tick();
      reset = 1'b1;
      tick();

      // Single windows: latency, value, tag and busy release.
      for (int v = 0; v < 7; v++) begin
         e = (RELU && vecs[v].exp[15]) ? 16'h0 : vecs[v].exp;
         send_window(vecs[v].pix, vecs[v].wgt, vecs[v].tag);
         tick();
         tick();
         check($sformatf("vec%0d_valid_n2", v), 32'(out_valid), 0);
         tick();
         check($sformatf("vec%0d_valid_n3", v), 32'(out_valid), 1);
         check($sformatf("vec%0d_data", v), 32'(out_data), 32'(e));
         check($sformatf("vec%0d_addr", v), 32'(out_addr), 32'(vecs[v].tag));
         check($sformatf("vec%0d_busy_n3", v), 32'(busy), 1);
         tick();
         check($sformatf("vec%0d_busy_n4", v), 32'(busy), 0);
      end

      // 16 windows back to back.
      got.delete();
      for (int k = 0; k < 16; k++) send_window(k + 1, 256, k);
      repeat (6) tick();
      check("b2b_count", 32'(got.size()), 16);
      for (int k = 0; k < 16 && k < got.size(); k++)
         check($sformatf("b2b_entry%0d", k), 32'(got[k]), ent(k, 9 * (k + 1)));
      check("b2b_err_frame", 32'(err_frame), 0);
      check("b2b_err_drop", 32'(err_drop), 0);
      check("b2b_busy", 32'(busy), 0);

      // Stalled output: four held, fifth dropped.
      got.delete();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) send_window(k + 2, 256, 'h20 + k);
      repeat (5) tick();
      check("stall_err_drop", 32'(err_drop), 1);
      check("stall_valid", 32'(out_valid), 1);
      check("stall_head", 32'({out_addr, out_data}), ent('h20, 18));
      repeat (3) tick();
      check("stall_hold", 32'({out_addr, out_data}), ent('h20, 18));
      pulse_clear();
      check("stall_clear", 32'(err_drop), 0);
      out_ready = 1'b1;
      repeat (6) tick();
      check("stall_count", 32'(got.size()), 4);
      for (int k = 0; k < 4 && k < got.size(); k++)
         check($sformatf("stall_entry%0d", k), 32'(got[k]), ent('h20 + k, 9 * (k + 2)));
      check("stall_drained", 32'(out_valid), 0);

      // Early in_last on beat 7, with err_clear in the same cycle.
      got.delete();
      for (int i = 0; i < 7; i++) begin
         if (i == 6) err_clear = 1'b1;
         drive_beat(256, 256, i == 6, 'h11);
      end
      err_clear = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      check("early_last_err", 32'(err_frame), 1);
      repeat (5) tick();
      check("early_last_no_out", 32'(got.size()), 0);
      send_window(512, 256, 'h12);
      repeat (4) tick();
      check("early_last_next_cnt", 32'(got.size()), 1);
      if (got.size() > 0) check("early_last_next", 32'(got[0]), ent('h12, 4608));

      // Ninth term without in_last.
      pulse_clear();
      check("frame_clear", 32'(err_frame), 0);
      for (int i = 0; i < 9; i++) drive_beat(256, 256, 1'b0, 'h13);
      in_valid = 1'b0;
      check("missing_last_err", 32'(err_frame), 1);
      send_window(256, 512, 'h14);
      repeat (4) tick();
      check("missing_last_cnt", 32'(got.size()), 2);
      if (got.size() > 1) check("missing_last_next", 32'(got[1]), ent('h14, 4608));

      // Reset mid-window with a result held and err_frame set.
      out_ready = 1'b0;
      send_window(256, 256, 'h2A);
      repeat (4) tick();
      check("pre_rst_valid", 32'(out_valid), 1);
      for (int i = 0; i < 5; i++) drive_beat(300, 300, 1'b0, 'h07);
      check("pre_rst_busy", 32'(busy), 1);
      reset = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_data", 32'(out_data), 0);
      check("mid_rst_addr", 32'(out_addr), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_err_frame", 32'(err_frame), 0);
      check("mid_rst_err_drop", 32'(err_drop), 0);
      in_valid = 1'b0;
      tick();
      reset     = 1'b1;
      out_ready = 1'b1;
      got.delete();
      tick();
      send_window(768, 256, 'h15);
      repeat (4) tick();
      check("post_rst_cnt", 32'(got.size()), 1);
      if (got.size() > 0) check("post_rst_result", 32'(got[0]), ent('h15, 6912));
      check("post_rst_err_frame", 32'(err_frame), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/conv_mac_accum.md
# conv_mac_accum

Downstream datapath stage for the CNN address controller: consumes the pixel/weight stream that controller-generated addresses fetch from the b-vector memory and filter register file, and performs the 9-term multiply-accumulate for each 3x3 window. It scales and saturates each window result and queues it in a small output FIFO. The FIFO drains to the output (dom) memory write port under a valid/ready handshake.

## Interface
- `FRAC_BITS`, default 8: arithmetic right-shift applied to the accumulator before saturation.
- `FIFO_DEPTH`, default 4: output queue entries; must be a power of 2.
- `clock`  in  1: single clock, posedge.
- `reset`  in  1: asynchronous, active-low. All state clears immediately on assertion.
- `in_valid`  in  1: a product term is present this cycle.
- `in_pixel`  in  16: signed pixel operand.
- `in_weight`  in  16: signed filter operand.
- `in_last`  in  1: this term is the 9th term of a window (the controller's ready_3_3, aligned to data).
- `in_tag`  in  6: window result address {layer, quad_select, subblock}. Sampled with the `in_last` beat.
- `out_valid`  out  1: FIFO head is valid.
- `out_ready`  in  1: the dom write port accepts the head this cycle.
- `out_data`  out  16: saturated window result.
- `out_addr`  out  6: tag of the head entry.
- `busy`  out  1: a window is partially accumulated, or the pipeline is non-empty.
- `err_frame`  out  1: sticky. `in_last` arrived on a term count other than 8, or term 9 arrived without `in_last`.
- `err_drop`  out  1: sticky. A result was dropped because the FIFO was full.
- `err_clear`  in  1: synchronous clear of both sticky flags.

## Operation
- Term counter `tcnt` has range 0..8. It increments on every `in_valid` beat and returns to 0 on the `in_last` beat.
- Stage P: on each `in_valid` beat, register the signed product `in_pixel*in_weight` (32 bits), the `last` flag, the tag and a frame-good bit.
  - Frame-good = (`in_last` == (`tcnt`==8)).
- Stage A: maintain a 36-bit signed accumulator.
  - The first valid term after a completed window loads the accumulator; every later term adds to it.
  - No bubble is needed between back-to-back windows.
- Framing error on any beat:
  - Set `err_frame`.
  - Reset `tcnt` to 0.
  - Discard the partial window; no FIFO write occurs.
  - The next beat starts a fresh window.
- Result formation, on a good final term:
  - Compute acc >>> `FRAC_BITS` (arithmetic shift).
  - Saturate to [-32768, 32767].
  - Write {tag, data} to the FIFO.
- FIFO full at write time: drop the result and set `err_drop`. If a pop happens in the same cycle, the write succeeds.
- Pop occurs when `out_valid` and `out_ready` are both high. `out_data` and `out_addr` are stable while `out_valid` is high and `out_ready` is low.
- `err_clear` together with a new error in the same cycle: the flag stays set (set wins).
- Reset mid-window: the accumulator, counter, pipeline and FIFO all empty. No partial result is ever emitted.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_addr`=0, `busy`=0, `err_frame`=0, `err_drop`=0.
- Throughput: one term per cycle; `in_valid` may stay high continuously.
- Latency: `in_last` sampled at edge N -> product registered at N+1 -> final sum at N+2 -> FIFO write at N+3. When the FIFO was empty, `out_valid` goes high after edge N+3.
- FIFO output is registered; there is no combinational path from `out_ready` to `out_valid`.
- `busy` falls one cycle after the last result enters the FIFO.

## Configuration
- `CONV_RELU_EN` defined: after saturation, negative results are clamped to 0 before the FIFO write.
- `CONV_RELU_EN` undefined: signed saturated results pass unchanged.
- Latency is identical in both builds.

## Structure
- Shared package `cnn_pkg` holds:
  - `DATA_W`=16, `ACC_W`=36, `TAG_W`=6.
  - `SAT_MAX`/`SAT_MIN` constants.
  - `conv_tag_t` packed struct {layer[1:0], quad[1:0], subblock[1:0]}.
- One sub-module, `conv_out_fifo`: synchronous FIFO with width `DATA_W+TAG_W`, depth `FIFO_DEPTH`, full/empty flags, and simultaneous push/pop allowed when full.

## Test plan
- Nine beats of pixel=256, weight=256 with `in_last` on beat 9, tag 6'h2A, `out_ready`=1 -> `out_data`=2304, `out_addr`=6'h2A, `out_valid` high 3 cycles after the last beat.
- Nine beats of 32767*32767 -> `out_data`=32767. Nine beats of -32768*32767 -> `out_data`=-32768, or 0 when built with `CONV_RELU_EN`.
- 144 back-to-back terms (16 windows), `out_ready`=1 -> 16 results in order, no gaps between windows, `err_*`=0.
- `out_ready`=0 across 5 windows -> 4 entries held, `err_drop`=1, first 4 results intact. Pulse `err_clear` -> flag clears.
- `in_last` on beat 7 -> `err_frame`=1, no output; the following correct 9-beat window produces the correct result.
- Assert `reset` low after beat 5 of a window -> all outputs 0 immediately; the next full window's result is correct.
